// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_pkg
// Purpose : Shared types and default constants for the instruction-fetch
//           prefetch stage (fetch FSM states, prefetch queue entry layout).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package if_pkg;

  localparam int unsigned C_ADDR_W  = 32;
  localparam int unsigned C_INSTR_W = 32;
  localparam int unsigned C_PC_STEP = 4;

  // One fetch in flight at most: either ready to issue or waiting for data.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  // Queue entry at the default widths; the top re-declares the same layout
  // at its own parameterised widths.
  typedef struct packed {
    logic [C_ADDR_W-1:0]  pc_next;
    logic [C_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_stage_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module  : if_stage_prefetch_if
// Purpose : Instruction-memory request/response bus.
// Ports   : imem_req/imem_addr   request (master -> memory)
//           imem_ready           request accept (memory -> master)
//           imem_rvalid/rdata    one-cycle response (memory -> master)
// Rev     : 1.0  initial release
// ============================================================================
interface if_stage_prefetch_if
  import if_pkg::*;
#(
  parameter int unsigned ADDR_W  = C_ADDR_W,
  parameter int unsigned INSTR_W = C_INSTR_W
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_queue
// Purpose : DEPTH-entry synchronous FIFO with flush, push, pop and occupancy.
//           Head is read combinationally from storage.
// Ports   : clk, rst (async, active-high)
//           i_flush  empty the queue (wins over push/pop)
//           i_push / i_data   write one entry (caller guarantees not full)
//           i_pop            drop head (caller guarantees not empty)
//           o_head           current head entry
//           o_count          occupancy 0..DEPTH
// Rev     : 1.0  initial release
// ============================================================================
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  entry_t           i_data,
  input  logic             i_pop,
  output entry_t           o_head,
  output logic [CNT_W-1:0] o_count
);

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_stage_prefetch.sv
`default_nettype none
// ============================================================================
// Module  : if_stage_prefetch
// Purpose : Instruction-fetch stage. Issues one request at a time to a
//           variable-latency instruction memory, buffers returned words in a
//           DEPTH-entry prefetch queue and presents {PC+PC_STEP, instruction,
//           valid} to the IF/ID register. Handles freeze, branch redirect
//           and discarding of an in-flight response after a redirect.
// Ports   : clk, rst            clock / async active-high reset
//           freeze              decode stall, head is held
//           Branch_taken        redirect (highest priority, flushes queue)
//           BranchAddr          redirect target
//           imem                instruction-memory bus (master side)
//           PC, Instruction     head entry (last popped value when empty)
//           if_valid            head entry valid
//           perf_fetched/perf_flushed  saturating counters, only when the
//                               macro IF_PERF_CNT_EN is defined
// Rev     : 1.0  initial release
// ============================================================================
module if_stage_prefetch
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = C_ADDR_W,
  parameter int unsigned       INSTR_W  = C_INSTR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       PC_STEP  = C_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                Branch_taken,
  input  logic [ADDR_W-1:0]   BranchAddr,
  if_stage_prefetch_if.master imem,
  output logic [ADDR_W-1:0]   PC,
  output logic [INSTR_W-1:0]  Instruction,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_flushed,
`endif
  output logic                if_valid
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc_next;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  w_fetch_pc_nxt;
  logic [ADDR_W-1:0]  r_req_addr;
  logic [ADDR_W-1:0]  w_req_addr_nxt;
  logic               r_discard;
  logic               w_discard_nxt;
  logic               w_req;
  logic               w_push;
  logic               w_pop;
  logic               w_outstanding;
  logic               w_has_room;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W:0]     w_occupancy;
  entry_t             w_head;
  entry_t             w_push_data;
  entry_t             r_last;

  assign w_outstanding = (r_state == WAIT);
  // Reserve a slot for the word in flight so a response can always land.
  assign w_occupancy   = {1'b0, w_count} + (CNT_W+1)'(w_outstanding);
  assign w_has_room    = (w_occupancy < (CNT_W+1)'(DEPTH));

  // --------------------------------------------------------------------------
  // Fetch FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
      r_discard  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_discard  <= w_discard_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_addr_nxt = r_req_addr;
    w_discard_nxt  = r_discard;
    w_req          = 1'b0;
    w_push         = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Held with a stable address until accepted; only a redirect or
        // reset withdraws it.
        w_req = w_has_room && !Branch_taken && !rst;
        if (Branch_taken) begin
          w_fetch_pc_nxt = BranchAddr;
        end else if (w_req && imem.imem_ready) begin
          w_state_nxt    = WAIT;
          w_req_addr_nxt = r_fetch_pc;
          w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(PC_STEP);
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          w_state_nxt   = IDLE;
          // A word returning in the redirect cycle is stale as well.
          w_push        = !r_discard && !Branch_taken;
          w_discard_nxt = 1'b0;
        end else if (Branch_taken) begin
          w_discard_nxt = 1'b1;
        end
        if (Branch_taken) begin
          w_fetch_pc_nxt = BranchAddr;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_fetch_pc;

  // --------------------------------------------------------------------------
  // Prefetch queue
  // --------------------------------------------------------------------------
  assign w_push_data.pc_next = r_req_addr + ADDR_W'(PC_STEP);
  assign w_push_data.instr   = imem.imem_rdata;
  assign w_pop               = if_valid && !freeze && !Branch_taken;

  if_fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_flush (Branch_taken),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Keeps the outputs steady at the last consumed entry while the queue is
  // empty, so stale storage never shows through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= '0;
    end else if (w_pop) begin
      r_last <= w_head;
    end
  end

  assign if_valid    = (w_count != '0);
  assign PC          = if_valid ? w_head.pc_next : r_last.pc_next;
  assign Instruction = if_valid ? w_head.instr   : r_last.instr;

`ifdef IF_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;
  logic [32:0] w_fetched_sum;
  logic [32:0] w_flushed_sum;
  logic [32:0] w_flush_inc;

  // An in-flight word is counted once, when it is first marked for discard.
  assign w_flush_inc   = Branch_taken
                       ? (33'(w_count) + 33'(w_outstanding && !imem.imem_rvalid && !r_discard))
                       : 33'd0;
  assign w_fetched_sum = {1'b0, r_perf_fetched} + 33'(w_push);
  assign w_flushed_sum = {1'b0, r_perf_flushed} + w_flush_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      r_perf_fetched <= w_fetched_sum[32] ? '1 : w_fetched_sum[31:0];
      r_perf_flushed <= w_flushed_sum[32] ? '1 : w_flushed_sum[31:0];
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage_prefetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_stage_prefetch
// Purpose : Self-checking bench for if_stage_prefetch: a queue-based model of
//           the fetch stage plus a variable-latency memory, directed
//           scenarios and a randomized run.
// Rev     : 1.0  initial release
// ============================================================================
module tb_if_stage_prefetch;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        Branch_taken = 1'b0;
  logic [31:0] BranchAddr = '0;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        if_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  if_stage_prefetch_if #(.ADDR_W(32), .INSTR_W(32)) ifc ();

  if_stage_prefetch #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .Branch_taken (Branch_taken),
    .BranchAddr   (BranchAddr),
    .imem         (ifc),
    .PC           (PC),
    .Instruction  (Instruction),
`ifdef IF_PERF_CNT_EN
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed),
`endif
    .if_valid     (if_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_addr;
  logic        m_busy;
  logic        m_discard;
  ent_t        m_q[$];
  ent_t        m_last;

  // memory state / knobs
  logic        mem_pend;
  int          mem_wait;
  logic [31:0] mem_addr;
  int          rdy_pct = 100;
  int          lat_lo = 0;
  int          lat_hi = 0;
  logic        spur_en = 1'b0;

  // values sampled in the last cycle
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, got no event expected event", name);
  endtask

  task automatic model_reset();
    m_fetch_pc = 32'h0;
    m_req_addr = 32'h0;
    m_busy     = 1'b0;
    m_discard  = 1'b0;
    m_q.delete();
    m_last     = '0;
    mem_pend   = 1'b0;
    mem_wait   = 0;
  endtask

  task automatic compare();
    logic ereq;
    ent_t eh;
    ereq = !m_busy && (m_q.size() < DEPTH) && !Branch_taken;
    chk("imem_req", 64'(ifc.imem_req), 64'(ereq));
    if (ereq) chk("imem_addr", 64'(ifc.imem_addr), 64'(m_fetch_pc));
    chk("if_valid", 64'(if_valid), 64'(m_q.size() != 0));
    eh = (m_q.size() != 0) ? m_q[0] : m_last;
    chk("PC", 64'(PC), 64'(eh.pc));
    chk("Instruction", 64'(Instruction), 64'(eh.instr));
    s_req = ifc.imem_req; s_addr = ifc.imem_addr; s_valid = if_valid;
    s_pc = PC; s_instr = Instruction;
  endtask

  task automatic model_update(input logic fz, input logic br, input logic [31:0] ba,
                              input logic rdy, input logic rv);
    logic ereq;
    ereq = !m_busy && (m_q.size() < DEPTH) && !br;
    if (br) begin
      m_q.delete();
      m_fetch_pc = ba;
      if (m_busy) begin
        if (rv) begin m_busy = 1'b0; m_discard = 1'b0; end
        else m_discard = 1'b1;
      end
    end else begin
      if (m_q.size() != 0 && !fz) m_last = m_q.pop_front();
      if (m_busy && rv) begin
        if (m_discard) m_discard = 1'b0;
        else m_q.push_back('{pc: m_req_addr + 32'd4, instr: memf(m_req_addr)});
        m_busy = 1'b0;
      end else if (ereq && rdy) begin
        m_busy     = 1'b1;
        m_req_addr = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic cycle(input logic fz, input logic br, input logic [31:0] ba);
    logic rdy, rv, hs;
    logic [31:0] rd, hs_addr;
    @(negedge clk);
    freeze = fz; Branch_taken = br; BranchAddr = ba;
    rdy = ($urandom_range(0, 99) < rdy_pct);
    rv = 1'b0;
    rd = $urandom;
    if (mem_pend) begin
      if (mem_wait == 0) begin rv = 1'b1; rd = memf(mem_addr); mem_pend = 1'b0; end
      else mem_wait--;
    end else if (spur_en && $urandom_range(0, 9) == 0) begin
      rv = 1'b1;
    end
    ifc.imem_ready = rdy; ifc.imem_rvalid = rv; ifc.imem_rdata = rd;
    #1 compare();
    hs = ifc.imem_req && rdy;
    hs_addr = ifc.imem_addr;
    @(posedge clk);
    if (hs) begin
      mem_pend = 1'b1;
      mem_wait = $urandom_range(lat_lo, lat_hi);
      mem_addr = hs_addr;
    end
    model_update(fz, br, ba, rdy, rv);
  endtask

  // Asserts reset mid-cycle, checks outputs go to zero at once, releases
  // just after a rising edge so the next cycle() is the first active cycle.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    freeze = 1'b0; Branch_taken = 1'b0; BranchAddr = '0;
    ifc.imem_ready = 1'b0; ifc.imem_rvalid = 1'b0; ifc.imem_rdata = '0;
    #1;
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_PC", 64'(PC), 64'd0);
    chk("rst_Instruction", 64'(Instruction), 64'd0);
    chk("rst_imem_req", 64'(ifc.imem_req), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic found;
    ifc.imem_ready = 1'b0; ifc.imem_rvalid = 1'b0; ifc.imem_rdata = '0;
    s_req = 0; s_valid = 0; s_addr = 0; s_pc = 0; s_instr = 0;
    model_reset();

    // 1. zero-wait memory: first instruction valid two cycles after release
    rdy_pct = 100; lat_lo = 0; lat_hi = 0;
    do_reset();
    cycle(0, 0, 0);
    chk("first_req_addr", 64'(s_addr), 64'h0);
    cycle(0, 0, 0);
    chk("c1_if_valid", 64'(s_valid), 64'd0);
    cycle(0, 0, 0);
    chk("c2_if_valid", 64'(s_valid), 64'd1);
    chk("c2_PC", 64'(s_pc), 64'h4);
    chk("c2_Instruction", 64'(s_instr), 64'(memf(32'h0)));
    repeat (8) cycle(0, 0, 0);

    // 2. freeze 10 cycles: queue fills, request stops, then 4 pops back to back
    do_reset();
    repeat (10) cycle(1, 0, 0);
    chk("frz_req_low", 64'(s_req), 64'd0);
    chk("frz_count", 64'(m_q.size()), 64'(DEPTH));
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0);
      chk("pop_valid", 64'(s_valid), 64'd1);
      chk("pop_PC", 64'(s_pc), 64'(32'd4 * (k + 1)));
    end

    // 3. latency 3, redirect in the second wait cycle
    lat_lo = 3; lat_hi = 3;
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 32'h100);
    cycle(0, 0, 0);
    chk("redir_addr", 64'(s_addr), 64'h100);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      cycle(0, 0, 0);
      if (s_valid) begin
        found = 1'b1;
        chk("redir_head_PC", 64'(s_pc), 64'h104);
        chk("redir_head_instr", 64'(s_instr), 64'(memf(32'h100)));
      end
    end
    if (!found) timeout("redir_head");

    // 4. redirect coinciding with a response while the queue is full
    lat_lo = 2; lat_hi = 2;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      cycle(1, 0, 0);
      found = (m_q.size() == 3) && mem_pend && (mem_wait == 0);
    end
    if (!found) timeout("full_setup");
    cycle(1, 1, 32'h200);
    cycle(1, 0, 0);
    chk("flush_if_valid", 64'(s_valid), 64'd0);
    repeat (6) cycle(0, 0, 0);

    // 5. fetch address wrap-around
    lat_lo = 0; lat_hi = 0;
    do_reset();
    cycle(0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0);
    chk("wrap_req0", 64'(s_addr), 64'hFFFF_FFFC);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("wrap_req1_valid", 64'(s_req), 64'd1);
    chk("wrap_req1_addr", 64'(s_addr), 64'h0);
    chk("wrap_head_PC", 64'(s_pc), 64'h0);

    // 6. reset mid-WAIT with 3 entries buffered, late response afterwards
    lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      cycle(1, 0, 0);
      found = (m_q.size() == 3) && m_busy;
    end
    if (!found) timeout("midwait_setup");
    do_reset();
    mem_pend = 1'b1; mem_wait = 0; mem_addr = 32'h40;
    cycle(0, 0, 0);
    chk("post_rst_req", 64'(s_req), 64'd1);
    chk("post_rst_addr", 64'(s_addr), 64'h0);
    repeat (6) cycle(0, 0, 0);

    // 7. randomized traffic
    rdy_pct = 70; lat_lo = 0; lat_hi = 3; spur_en = 1'b1;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic fz, br;
      fz = ($urandom_range(0, 99) < 30);
      br = ($urandom_range(0, 99) < 6);
      cycle(fz, br, $urandom & 32'hFFFF_FFFC);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
